maze_port_arbiter: RTL and testbench
====================================

Name: maze_port_arbiter

Overview:
- Time-shares the single read port of the maze RAM between the VGA pixel fetch and wall-collision lookups from tanks and bullets.
- Cycles alternate between two slots: even cycles go to the display path, odd cycles go to the requesters.
- Requesters present pixel coordinates. The block converts them to the maze word/bit address, arbitrates round-robin, and returns a single wall bit.
- It sits between the VGA interface's maze RAM (1-cycle registered read) and the tank/bullet motion logic.

Parameters:
- NUM_REQ, 4, number of collision requesters (tank1, tank2, bullet1, bullet2).
- ADDR_W, 10, maze RAM word-address width.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- vga_addr  in  ADDR_W  word address from the display path.
- vga_data  out  32  maze word returned to the display path.
- ram_rdaddress  out  ADDR_W  maze RAM read address.
- ram_q  in  32  maze RAM read data, valid 1 cycle after the address.
- req  in  NUM_REQ  per-requester lookup request, level.
- req_x  in  NUM_REQ*10  packed pixel X, requester i at bits [10i+9:10i].
- req_y  in  NUM_REQ*10  packed pixel Y, same packing as req_x.
- gnt  out  NUM_REQ  one-hot pulse; the request is accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot pulse; rsp_wall is valid for that requester.
- rsp_wall  out  1  looked-up maze bit (1 = wall).
- phase  out  1  current slot: 0 = VGA, 1 = arbiter.

Behaviour:
- Reset (async assert, sync release), all outputs and state cleared:
  - phase=0, state IDLE, rr pointer=NUM_REQ-1 (so req[0] wins first).
  - gnt=0, rsp_valid=0, rsp_wall=0, vga_data=0.
- phase toggles every CLK.
- Read address:
  - ram_rdaddress = vga_addr when phase=0.
  - ram_rdaddress = latched requester word when phase=1 and a grant occurs this cycle.
  - Otherwise ram_rdaddress = vga_addr.
- vga_data loads ram_q on every phase=1 cycle and holds otherwise, giving the display path 2-cycle-stable data.
- Address math for the selected requester, all unsigned:
  - byte = (x>>2) + (y>>2)*160, 15 bits.
  - word = byte[14:5], bit = byte[4:0].
  - Max in-range byte = 19199, giving word 599, bit 31.
- Out of range (x>=640 or y>=480): the result is forced to wall=1 and the RAM data is ignored. Latency is identical to an in-range lookup.
- FSM:
  - IDLE: on a phase=1 cycle with any req bit set, select the first set bit searching from rr+1 modulo NUM_REQ. In the same cycle:
    - pulse gnt[w];
    - drive ram_rdaddress = word(w);
    - latch w, bit(w) and the out-of-range flag;
    - set rr=w;
    - go to WAIT.
  - IDLE, no request or phase=0: no grant is issued.
  - WAIT (phase=0): capture the result, rsp_wall <= oor ? 1 : ram_q[bit]; go to RESP.
  - RESP (phase=1): rsp_valid[w]=1 for exactly this cycle; rsp_wall holds. The FSM treats this cycle as IDLE, so a new grant may issue in the same cycle.
- Latency and throughput:
  - gnt to rsp_valid is 2 cycles.
  - Peak rate is one lookup per 2 cycles.
  - Each requester is served at most once per NUM_REQ grants while others are pending.
- Requester rules:
  - Hold req, x and y until gnt; x/y are sampled only in the gnt cycle.
  - req still high after gnt is treated as a new request and re-arbitrated.
  - req dropping before gnt withdraws the request with no side effect.
- rsp_wall holds its last value between responses.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority.
- Reset mid-lookup aborts it: no rsp_valid is produced, and the first post-reset grant goes to the lowest set req index.

Test Plan:
- Release reset, vga_addr=37, ram_q returns word 37 contents -> vga_data equals that word after the first phase=1 cycle; gnt=0 and rsp_valid=0 throughout.
- req[0] with x=100, y=40 -> gnt[0] on the first phase=1 cycle with ram_rdaddress=50; ram_q[25]=1 -> rsp_valid[0] 2 cycles later with rsp_wall=1. Repeat with ram_q[25]=0 -> rsp_wall=0.
- req[1] with x=639, y=479 -> ram_rdaddress=599, bit 31 used. req[1] with x=640, y=0 -> rsp_wall=1 regardless of ram_q, same 2-cycle latency.
- All four req held high continuously -> grant order 0,1,2,3,0,1…, one grant per phase=1 cycle, each rsp_valid aligned with the following grant.
- Assert RESET_N=0 during WAIT after gnt[2] -> no rsp_valid[2]; all outputs are 0 immediately. After release with req=4'b1100 -> gnt[2] is granted first.
- req[3] asserted on a phase=0 cycle and dropped before the next cycle -> no gnt and no rsp_valid. vga_data tracks vga_addr unaffected throughout all scenarios.

Source files
------------

// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter: time-shares the maze RAM read port. Even cycles (phase=0)
// serve the VGA fetch; odd cycles (phase=1) serve one round-robin-selected
// wall-collision lookup. Requesters supply pixel coordinates, which are turned
// into a maze word/bit address. The looked-up wall bit comes back 2 cycles after
// the grant. RESET_N is expected to be released synchronously to CLK by the
// reset tree. Its assertion is asynchronous.
module maze_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [ADDR_W-1:0]       vga_addr,
  output logic [31:0]             vga_data,
  output logic [ADDR_W-1:0]       ram_rdaddress,
  input  logic [31:0]             ram_q,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*10-1:0]   req_x,
  input  logic [NUM_REQ*10-1:0]   req_y,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_wall,
  output logic                    phase
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]   RR_INIT  = SEL_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte offset of pixel (x,y) in the maze bitmap: 4x4 pixel cells, 160 cells per row.
  function automatic logic [14:0] pix_byte(input logic [9:0] x, input logic [9:0] y);
    logic [15:0] sum;
    sum = {8'd0, x[9:2]} + ({8'd0, y[9:2]} * 16'd160);
    return sum[14:0];
  endfunction

  // Coordinates outside the 640x480 screen always read as wall.
  function automatic logic pix_oor(input logic [9:0] x, input logic [9:0] y);
    return (x >= 10'd640) || (y >= 10'd480);
  endfunction

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [4:0]         bit_q, bit_d;
  logic               oor_q, oor_d;
  logic               rsp_wall_q, rsp_wall_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        vga_data_q, vga_data_d;

  logic [SEL_W-1:0]   win_s;
  logic               win_found_s;
  logic               grant_s;
  logic [9:0]         sel_x_s, sel_y_s;
  logic [14:0]        sel_byte_s;
  logic               sel_oor_s;

  // Round-robin search: first set req bit after the last winner, wrapping.
  always_comb begin
    logic [SEL_W:0] idx;
    win_s       = '0;
    win_found_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (SEL_W+1)'(k);
      idx = (idx >= (SEL_W+1)'(NUM_REQ)) ? (idx - (SEL_W+1)'(NUM_REQ)) : idx;
      if (!win_found_s && req[idx[SEL_W-1:0]]) begin
        win_found_s = 1'b1;
        win_s       = idx[SEL_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant decision, winner address math and the shared RAM read address.
  always_comb begin
    grant_s       = phase_q && (state_q != ST_WAIT) && win_found_s;
    sel_x_s       = req_x[10*win_s +: 10];
    sel_y_s       = req_y[10*win_s +: 10];
    sel_byte_s    = pix_byte(sel_x_s, sel_y_s);
    sel_oor_s     = pix_oor(sel_x_s, sel_y_s);
    gnt           = grant_s ? (ONE_HOT0 << win_s) : '0;
    ram_rdaddress = grant_s ? ADDR_W'(sel_byte_s[14:5]) : vga_addr;
  end

  // Next-state logic for the slot phase, lookup FSM and response registers.
  always_comb begin
    phase_d     = ~phase_q;
    state_d     = state_q;
    rr_d        = rr_q;
    sel_d       = sel_q;
    bit_d       = bit_q;
    oor_d       = oor_q;
    rsp_wall_d  = rsp_wall_q;
    rsp_valid_d = '0;
    vga_data_d  = phase_q ? ram_q : vga_data_q;
    case (state_q)
      ST_WAIT: begin
        rsp_wall_d  = oor_q ? 1'b1 : ram_q[bit_q];
        rsp_valid_d = ONE_HOT0 << sel_q;
        state_d     = ST_RESP;
      end
      default: begin
        // IDLE and RESP both accept a new grant; RESP is always a phase=1 slot.
        if (grant_s) begin
          state_d = ST_WAIT;
          rr_d    = win_s;
          sel_d   = win_s;
          bit_d   = sel_byte_s[4:0];
          oor_d   = sel_oor_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers; async reset aborts any lookup in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      rr_q        <= RR_INIT;
      sel_q       <= '0;
      bit_q       <= 5'd0;
      oor_q       <= 1'b0;
      rsp_wall_q  <= 1'b0;
      rsp_valid_q <= '0;
      vga_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rr_q        <= rr_d;
      sel_q       <= sel_d;
      bit_q       <= bit_d;
      oor_q       <= oor_d;
      rsp_wall_q  <= rsp_wall_d;
      rsp_valid_q <= rsp_valid_d;
      vga_data_q  <= vga_data_d;
    end
  end

  assign vga_data  = vga_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wall  = rsp_wall_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed testbench for maze_port_arbiter with a 1-cycle registered maze RAM model.
module tb_maze_port_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [9:0]  vga_addr;
  logic [31:0] vga_data;
  logic [9:0]  ram_rdaddress;
  logic [31:0] ram_q;
  logic [3:0]  req;
  logic [39:0] req_x;
  logic [39:0] req_y;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic        rsp_wall;
  logic        phase;

  logic [31:0] mem [0:1023];
  int          n_run;
  int          n_fail;
  logic        exp_ph;

  maze_port_arbiter #(.NUM_REQ(4), .ADDR_W(10)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .vga_addr(vga_addr), .vga_data(vga_data),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q), .req(req), .req_x(req_x),
    .req_y(req_y), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_wall(rsp_wall),
    .phase(phase)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Maze RAM: registered read, data valid one cycle after the address.
  always @(posedge CLK) ram_q <= mem[ram_rdaddress];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_io(input string tag, input logic [3:0] eg, input logic [3:0] ev);
    chk({tag, ".phase"}, {31'd0, phase}, {31'd0, exp_ph});
    chk({tag, ".gnt"}, {28'd0, gnt}, {28'd0, eg});
    chk({tag, ".rsp_valid"}, {28'd0, rsp_valid}, {28'd0, ev});
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    exp_ph = ~exp_ph;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic set_xy(input int i, input logic [9:0] x, input logic [9:0] y);
    req_x[10*i +: 10] = x;
    req_y[10*i +: 10] = y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_run = 0; n_fail = 0; exp_ph = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[0]   = 32'h5A00_0000;
    mem[5]   = 32'h0000_0000;
    mem[50]  = 32'h0200_0000;
    mem[599] = 32'h8000_0000;
    RESET_N = 1'b0; req = 4'd0; req_x = 40'd0; req_y = 40'd0; vga_addr = 10'd37;

    // Reset state
    repeat (3) @(posedge CLK);
    settle();
    chk_io("reset", 4'd0, 4'd0);
    chk("reset.wall", {31'd0, rsp_wall}, 32'd0);
    chk("reset.vga", vga_data, 32'd0);

    // VGA path: address 37 fetched, vga_data valid after the first phase=1 cycle
    RESET_N = 1'b1; exp_ph = 1'b0; #1;
    chk_io("c0", 4'd0, 4'd0);
    chk("c0.rdaddr", {22'd0, ram_rdaddress}, 32'd37);
    cyc(); settle();
    chk_io("c1", 4'd0, 4'd0);
    chk("c1.vga", vga_data, 32'd0);
    cyc();
    req = 4'b0001; set_xy(0, 10'd100, 10'd40);
    settle();
    chk_io("c2", 4'd0, 4'd0);
    chk("c2.vga", vga_data, 32'h5A00_0025);
    chk("c2.rdaddr", {22'd0, ram_rdaddress}, 32'd37);

    // req0 at (100,40): word 50 bit 25 set -> wall 1
    cyc(); settle();
    chk_io("c3", 4'b0001, 4'd0);
    chk("c3.rdaddr", {22'd0, ram_rdaddress}, 32'd50);
    cyc(); req = 4'b0000; settle();
    chk_io("c4", 4'd0, 4'd0);
    cyc(); settle();
    chk_io("c5", 4'd0, 4'b0001);
    chk("c5.wall", {31'd0, rsp_wall}, 32'd1);

    // Same lookup with only bit 25 clear -> wall 0
    cyc(); mem[50] = 32'hFDFF_FFFF; req = 4'b0001; settle();
    chk_io("c6", 4'd0, 4'd0);
    chk("c6.wall_hold", {31'd0, rsp_wall}, 32'd1);
    chk("c6.vga", vga_data, 32'h5A00_0025);
    cyc(); settle();
    chk_io("c7", 4'b0001, 4'd0);
    chk("c7.rdaddr", {22'd0, ram_rdaddress}, 32'd50);
    cyc(); req = 4'b0000; settle();
    chk_io("c8", 4'd0, 4'd0);
    cyc(); settle();
    chk_io("c9", 4'd0, 4'b0001);
    chk("c9.wall", {31'd0, rsp_wall}, 32'd0);

    // req1 at (639,479): word 599 bit 31
    cyc(); req = 4'b0010; set_xy(1, 10'd639, 10'd479); settle();
    chk_io("c10", 4'd0, 4'd0);
    cyc(); settle();
    chk_io("c11", 4'b0010, 4'd0);
    chk("c11.rdaddr", {22'd0, ram_rdaddress}, 32'd599);
    cyc(); req = 4'b0000; settle();
    cyc(); settle();
    chk_io("c13", 4'd0, 4'b0010);
    chk("c13.wall", {31'd0, rsp_wall}, 32'd1);

    // req1 at (640,0): out of range, word 5 is all zeros but wall forced to 1
    cyc(); req = 4'b0010; set_xy(1, 10'd640, 10'd0); settle();
    cyc(); settle();
    chk_io("c15", 4'b0010, 4'd0);
    cyc(); req = 4'b0000; settle();
    chk_io("c16", 4'd0, 4'd0);
    cyc(); settle();
    chk_io("c17", 4'd0, 4'b0010);
    chk("c17.wall", {31'd0, rsp_wall}, 32'd1);

    // (639,479) again with bit 31 clear, other bits set -> wall 0
    cyc(); mem[599] = 32'h7FFF_FFFF; req = 4'b0010; set_xy(1, 10'd639, 10'd479); settle();
    cyc(); settle();
    chk_io("c19", 4'b0010, 4'd0);
    cyc(); req = 4'b0000; settle();
    cyc(); settle();
    chk_io("c21", 4'd0, 4'b0010);
    chk("c21.wall", {31'd0, rsp_wall}, 32'd0);

    // All four held; last winner was 1 so order is 2,3,0,1,2
    // walls: r2 (640,0) oor=1, r3 (4,0) word0 bit1=0, r0 word50 bit25=0, r1 (0,480) oor=1
    cyc(); req = 4'b1111;
    set_xy(0, 10'd100, 10'd40); set_xy(1, 10'd0, 10'd480);
    set_xy(2, 10'd640, 10'd0);  set_xy(3, 10'd4, 10'd0);
    settle();
    chk_io("c22", 4'd0, 4'd0);
    chk("c22.vga", vga_data, 32'h5A00_0025);
    cyc(); settle(); chk_io("rr0", 4'b0100, 4'd0);
    cyc(); settle(); chk_io("rr0w", 4'd0, 4'd0);
    cyc(); settle(); chk_io("rr1", 4'b1000, 4'b0100);
    chk("rr1.wall", {31'd0, rsp_wall}, 32'd1);
    chk("rr1.rdaddr", {22'd0, ram_rdaddress}, 32'd0);
    cyc(); settle(); chk_io("rr1w", 4'd0, 4'd0);
    cyc(); settle(); chk_io("rr2", 4'b0001, 4'b1000);
    chk("rr2.wall", {31'd0, rsp_wall}, 32'd0);
    cyc(); settle();
    cyc(); settle(); chk_io("rr3", 4'b0010, 4'b0001);
    chk("rr3.wall", {31'd0, rsp_wall}, 32'd0);
    cyc(); settle();
    cyc(); settle(); chk_io("rr4", 4'b0100, 4'b0010);
    chk("rr4.wall", {31'd0, rsp_wall}, 32'd1);

    // Reset during WAIT after gnt[2]: everything clears, no response
    cyc(); RESET_N = 1'b0; req = 4'b0000; exp_ph = 1'b0; #1;
    chk_io("rst_mid", 4'd0, 4'd0);
    chk("rst_mid.wall", {31'd0, rsp_wall}, 32'd0);
    chk("rst_mid.vga", vga_data, 32'd0);
    settle(); chk_io("rst_hold0", 4'd0, 4'd0);
    settle(); chk_io("rst_hold1", 4'd0, 4'd0);
    req = 4'b1100; RESET_N = 1'b1; exp_ph = 1'b0; #1;
    chk_io("rel0", 4'd0, 4'd0);
    cyc(); settle();
    chk_io("rel1", 4'b0100, 4'd0);
    chk("rel1.rdaddr", {22'd0, ram_rdaddress}, 32'd5);
    cyc(); req = 4'b0000; settle();
    chk_io("rel2", 4'd0, 4'd0);
    cyc(); settle();
    chk_io("rel3", 4'd0, 4'b0100);
    chk("rel3.wall", {31'd0, rsp_wall}, 32'd1);

    // Short req3 pulse within a phase=0 cycle: withdrawn, no grant; VGA moves to 100
    cyc(); vga_addr = 10'd100; req = 4'b1000; set_xy(3, 10'd8, 10'd8);
    #2; req = 4'b0000; settle();
    chk_io("wd0", 4'd0, 4'd0);
    cyc(); settle(); chk_io("wd1", 4'd0, 4'd0);
    cyc(); settle(); chk_io("wd2", 4'd0, 4'd0);
    chk("wd2.vga", vga_data, 32'h5A00_0064);
    cyc(); settle(); chk_io("wd3", 4'd0, 4'd0);
    chk("wd3.wall_hold", {31'd0, rsp_wall}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
